instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, byte-address width shared with the instruction memory.
REQ-002 Parameter RESET_PC, default 0, first byte address fetched after reset.
REQ-003 Parameter FIFO_DEPTH, default 4, prefetch buffer entries, power of two, at least 2.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 addr_o  output  ADDR_WIDTH  byte address to instruction memory.
REQ-007 bus_io  inout tri  32  shared memory data bus, sampled on read, driven only per REQ-024.
REQ-008 re_o  output  1  memory read enable; memory returns data combinationally in the same cycle.
REQ-009 we_o  output  1  memory write enable.
REQ-010 redirect_i  input  1  branch or jump redirect request.
REQ-011 redirect_pc_i  input  ADDR_WIDTH  redirect target; bits [1:0] ignored and treated as zero.
REQ-012 instr_valid_o  output  1  head instruction available.
REQ-013 instr_o  output  32  head instruction word.
REQ-014 instr_pc_o  output  ADDR_WIDTH  byte address of the head instruction.
REQ-015 instr_ready_i  input  1  decode accepts the head entry.

Function
REQ-016 Read issue: re_o = state FETCH and not redirect_i and (count < FIFO_DEPTH or pop), where pop = instr_valid_o and instr_ready_i; addr_o = pc.
REQ-017 On a rising edge with re_o high, {pc, bus_io} is pushed to the FIFO tail and pc advances by 4, wrapping modulo 2^ADDR_WIDTH.
REQ-018 instr_valid_o is high exactly when the FIFO is non-empty; instr_o and instr_pc_o present the head entry.
REQ-019 A push and a pop in the same cycle leave count unchanged; a full FIFO with a pop still issues a read.
REQ-020 Steady-state throughput is one instruction per cycle when instr_ready_i stays high.
REQ-021 Redirect: on the edge with redirect_i high, the FIFO is flushed (count set to 0), pc is loaded with {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}, and no push occurs; a pop in that cycle is discarded with the flush.
REQ-022 Redirect latency: instr_valid_o is low in cycle N+1 after a redirect in cycle N; the target is read in N+1 and is valid in N+2.
REQ-023 Back-to-back redirects: the last redirect wins, and no stale entry becomes visible.
REQ-024 bus_io is released to high impedance at all times except the condition in REQ-030; we_o is low in FETCH.

Reset
REQ-025 While rst_n is low at an edge: pc is set to RESET_PC and count to 0; re_o, we_o and instr_valid_o are 0; instr_o and instr_pc_o are 0; bus_io is released.
REQ-026 Reset asserted mid-operation discards all buffered entries in the same edge and overrides any redirect.
REQ-027 After rst_n rises, the first read of RESET_PC is issued in the same cycle and is valid the next cycle (FETCH state), unless REQ-029 applies.

Configuration
REQ-028 The macro FETCH_LOADER_EN compiles in a boot loader that writes instructions into memory over the same bus.
REQ-029 With FETCH_LOADER_EN: added ports are load_valid_i (1), load_data_i (32), load_done_i (1) and load_ready_o (1); reset enters state LOAD with the load address set to RESET_PC.
REQ-030 In LOAD: load_ready_o = 1; when load_valid_i is high, we_o = 1, addr_o = load address and bus_io is driven with load_data_i; on each accepted word the load address advances by 4; re_o = 0.
REQ-031 load_done_i in LOAD moves the block to FETCH with pc = RESET_PC; if load_valid_i is high in the same cycle, that word is written first.
REQ-032 Without FETCH_LOADER_EN: the loader ports are absent, state LOAD does not exist, we_o is tied 0, and bus_io is never driven.

Structure
REQ-033 The shared package holds the fetch_entry_t struct {pc, instr}, the fetch_state_t enum {LOAD, FETCH}, and the ADDR_WIDTH constant.
REQ-034 The FIFO is a sub-module fetch_fifo with push, pop, flush, full, empty and count, instantiated once.

Verification
REQ-035 Scenario: reset release with memory preloaded with 0x11,0x22,0x33 at 0,4,8 and ready=1 -> valid from cycle 1, instr_o sequence 0x11,0x22,0x33, instr_pc_o sequence 0,4,8.
REQ-036 Scenario: ready=0 for 8 cycles -> exactly 4 reads issued, re_o low afterwards; ready raised -> entries 0,4,8,12 in order, then the fetch of 16 resumes.
REQ-037 Scenario: redirect to 0x103 while the FIFO holds 3 entries -> valid low next cycle, then instr_pc_o=0x100 with its memory word, no stale entries.
REQ-038 Scenario: rst_n pulsed low for one cycle with a full FIFO -> outputs zero, then fetch restarts at RESET_PC.
REQ-039 Scenario (FETCH_LOADER_EN): load 0xA,0xB with load_done_i asserted alongside 0xB -> memory[0]=0xA, memory[4]=0xB, then fetch returns 0xA,0xB.
REQ-040 Scenario: pc=2^ADDR_WIDTH-4 -> the next fetched instr_pc_o is 0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
//
// Purpose: types and constants shared by the instruction fetch unit and its
// prefetch FIFO.
//   ADDR_WIDTH     default byte-address width of the instruction memory
//   INSTR_WIDTH    instruction word width (the memory bus width)
//   fetch_entry_t  one prefetch buffer entry: {pc, instr}
//   fetch_state_t  LOAD (boot loader writes memory) / FETCH (normal fetching)
//   ptr_width()    pointer width for a power-of-two buffer depth
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int ADDR_WIDTH  = 16;
    localparam int INSTR_WIDTH = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        LOAD  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    // A depth-1 buffer would still need a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
//
// Purpose: prefetch buffer between the memory read port and decode.
// Circular buffer with a power-of-two depth so the pointers wrap naturally.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset, empties the buffer
//   push       write push_data at the tail (honoured when not full, or when
//              a pop frees a slot in the same cycle)
//   pop        drop the head entry (ignored when empty)
//   flush      discard every entry; wins over push and pop
//   push_data  entry written on push
//   head_data  oldest entry
//   full       count == DEPTH
//   empty      count == 0
//   count      number of stored entries
// ---------------------------------------------------------------------------
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = ADDR_WIDTH + INSTR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [DATA_W-1:0]       push_data,
    output logic [DATA_W-1:0]       head_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = ptr_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign full      = (count_q == (PW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Purpose: instruction fetch unit. Reads sequential words from a
// combinational instruction memory into a prefetch FIFO, presents the head
// entry to decode, and restarts at a new address on a redirect.
//
// Optional feature: define FETCH_LOADER_EN to compile in a boot loader. Reset
// then enters LOAD, where words presented on load_* are written to memory at
// consecutive addresses from RESET_PC until load_done_i moves to FETCH.
//
// Ports:
//   clk             clock, rising edge
//   rst_n           synchronous active-low reset
//   addr_o          memory byte address
//   bus_io          shared 32-bit memory data bus (driven only when loading)
//   re_o / we_o     memory read / write enable
//   redirect_i      branch/jump redirect, redirect_pc_i is the target
//   instr_valid_o   head entry available; instr_o / instr_pc_o are its
//                   word and byte address
//   instr_ready_i   decode accepts the head entry
//   load_valid_i, load_data_i, load_done_i, load_ready_o  (FETCH_LOADER_EN)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] addr_o,
    inout  tri   [31:0]           bus_io,
    output logic                  re_o,
    output logic                  we_o,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i
`ifdef FETCH_LOADER_EN
    ,
    input  logic                  load_valid_i,
    input  logic [31:0]           load_data_i,
    input  logic                  load_done_i,
    output logic                  load_ready_o
`endif
);

    import instr_fetch_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

`ifdef FETCH_LOADER_EN
    localparam fetch_state_t RESET_STATE = LOAD;
`else
    localparam fetch_state_t RESET_STATE = FETCH;
`endif

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
`ifdef FETCH_LOADER_EN
    logic [ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
    logic                  bus_oe;
`endif

    logic                  head_valid;
    logic                  pop;
    logic                  flush;
    logic [EW-1:0]         head_entry;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [31:0]           head_instr;
    logic                  fifo_empty;
    logic                  fifo_full_unused;
    logic [CW-1:0]         fifo_count;

    // Outputs are forced quiet while reset is held, so the head is only
    // visible and consumable with rst_n high.
    assign head_valid = rst_n && !fifo_empty;
    assign pop        = head_valid && instr_ready_i;
    assign flush      = redirect_i && (state_q == FETCH);
    assign {head_pc, head_instr} = head_entry;

    // Occupancy is checked through the count compare below, so full is spare.
    fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (re_o),
        .pop       (pop),
        .flush     (flush),
        .push_data ({pc_q, bus_io}),
        .head_data (head_entry),
        .full      (fifo_full_unused),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            pc_q        <= RESET_PC;
`ifdef FETCH_LOADER_EN
            load_addr_q <= RESET_PC;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
`ifdef FETCH_LOADER_EN
            load_addr_q <= load_addr_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
`ifdef FETCH_LOADER_EN
        load_addr_d = load_addr_q;
`endif
        case (state_q)
            LOAD: begin
`ifdef FETCH_LOADER_EN
                if (load_valid_i) begin
                    load_addr_d = load_addr_q + ADDR_WIDTH'(4);
                end
                // A word arriving with done is still written this cycle.
                if (load_done_i) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                end
`else
                state_d = FETCH;
`endif
            end
            FETCH: begin
                if (redirect_i) begin
                    pc_d = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
                end else if (re_o) begin
                    pc_d = pc_q + ADDR_WIDTH'(4);
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        re_o          = 1'b0;
        we_o          = 1'b0;
        addr_o        = pc_q;
        instr_valid_o = head_valid;
        instr_o       = '0;
        instr_pc_o    = '0;
`ifdef FETCH_LOADER_EN
        load_ready_o  = 1'b0;
        bus_oe        = 1'b0;
`endif
        if (head_valid) begin
            instr_o    = head_instr;
            instr_pc_o = head_pc;
        end
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    // A slot freed by this cycle's pop can be refilled at once.
                    re_o = !redirect_i && ((fifo_count < CW'(FIFO_DEPTH)) || pop);
                end
                LOAD: begin
`ifdef FETCH_LOADER_EN
                    load_ready_o = 1'b1;
                    if (load_valid_i) begin
                        we_o   = 1'b1;
                        addr_o = load_addr_q;
                        bus_oe = 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // Without the loader the bus is only ever sampled, never driven.
`ifdef FETCH_LOADER_EN
    assign bus_io = bus_oe ? load_data_i : 32'bz;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Randomized self-checking bench for instr_fetch. A word-addressed memory
// answers reads combinationally on the shared bus; a queue-based model of
// the prefetch buffer predicts every cycle's outputs. Define FETCH_LOADER_EN
// to also exercise the boot loader.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int          AW     = 16;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] RST_PC = 16'h0000;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr_o;
    tri   [31:0] bus;
    logic        re_o;
    logic        we_o;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [15:0] instr_pc_o;
    logic        instr_ready;
`ifdef FETCH_LOADER_EN
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_done;
    logic        load_ready_o;
`endif

    logic [31:0] mem [0:16383];

    entry_t      modelQ[$];
    logic [15:0] modelPc;
    bit          modelLoading;
    int          checks;
    int          failures;
    int          reCount;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_WIDTH (AW),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr_o        (addr_o),
        .bus_io        (bus),
        .re_o          (re_o),
        .we_o          (we_o),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready)
`ifdef FETCH_LOADER_EN
        ,
        .load_valid_i  (load_valid),
        .load_data_i   (load_data),
        .load_done_i   (load_done),
        .load_ready_o  (load_ready_o)
`endif
    );

    // Memory answers a read in the same cycle.
    assign bus = re_o ? mem[addr_o[15:2]] : 32'bz;

`ifdef FETCH_LOADER_EN
    always @(posedge clk) begin
        if (we_o) mem[addr_o[15:2]] <= bus;
    end
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One cycle in FETCH: drive inputs, compare against the model, advance
    // both across the rising edge. Starts and ends just after a falling edge.
    task automatic applyStimulus(input bit ready, input bit redir, input logic [15:0] target);
        bit expValid;
        bit expPop;
        bit expRe;
        instr_ready = ready;
        redirect    = redir;
        redirect_pc = target;
        #1;
        expValid = !modelLoading && (modelQ.size() > 0);
        checkOutput("valid", 32'(instr_valid_o), 32'(expValid));
        if (expValid) begin
            checkOutput("instr", instr_o, modelQ[0].instr);
            checkOutput("instr_pc", 32'(instr_pc_o), 32'(modelQ[0].pc));
        end
        expPop = expValid && ready;
        expRe  = !modelLoading && !redir && (modelQ.size() < DEPTH || expPop);
        checkOutput("re", 32'(re_o), 32'(expRe));
        if (expRe) checkOutput("read_addr", 32'(addr_o), 32'(modelPc));
        checkOutput("we", 32'(we_o), 32'd0);
        if (re_o) reCount++;
        @(posedge clk);
        if (redir) begin
            modelQ.delete();
            modelPc = target & 16'hFFFC;
        end else begin
            if (expPop) void'(modelQ.pop_front());
            if (expRe) begin
                modelQ.push_back('{pc: modelPc, instr: mem[modelPc[15:2]]});
                modelPc = modelPc + 16'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
        checkOutput({tag, "_instr"}, instr_o, 32'd0);
        checkOutput({tag, "_pc"}, 32'(instr_pc_o), 32'd0);
        checkOutput({tag, "_re"}, 32'(re_o), 32'd0);
        checkOutput({tag, "_we"}, 32'(we_o), 32'd0);
    endtask

    // Hold reset across one rising edge. With the loader built in, leave
    // LOAD straight away unless the caller wants to load words itself.
    task automatic doReset(input bit stayInLoad);
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        #1;
        checkQuiet("in_reset");
        @(posedge clk);
        @(negedge clk);
        checkQuiet("after_reset_edge");
        rst_n = 1'b1;
        modelQ.delete();
        modelPc = RST_PC;
`ifdef FETCH_LOADER_EN
        modelLoading = 1'b1;
        if (!stayInLoad) begin
            load_done = 1'b1;
            #1;
            checkOutput("load_ready", 32'(load_ready_o), 32'd1);
            checkOutput("load_re", 32'(re_o), 32'd0);
            @(posedge clk);
            modelLoading = 1'b0;
            @(negedge clk);
            load_done = 1'b0;
        end
`else
        modelLoading = 1'b0;
        if (stayInLoad) $display("[TB] loader not built, continuing in FETCH");
`endif
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reCount     = 0;
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
`ifdef FETCH_LOADER_EN
        load_valid  = 1'b0;
        load_data   = '0;
        load_done   = 1'b0;
`endif
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;

        // Sequential fetch straight out of reset.
        doReset(1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 16'h0);

        // Decode stalled: the buffer fills with exactly DEPTH reads.
        doReset(1'b0);
        reCount = 0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("reads_while_stalled", 32'(reCount), 32'(DEPTH));
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 16'h0);

        // Redirect to an unaligned target with three entries buffered.
        doReset(1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("buffered_before_redirect", 32'(modelQ.size()), 32'd3);
        applyStimulus(1'b1, 1'b1, 16'h0103);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'h0);

        // Back-to-back redirects, the last one wins.
        applyStimulus(1'b1, 1'b1, 16'h0200);
        applyStimulus(1'b1, 1'b1, 16'h0302);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'h0);

        // Reset pulse with a full buffer.
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 16'h0);
        doReset(1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'h0);

        // Address wrap at the top of memory.
        applyStimulus(1'b1, 1'b1, 16'hFFFC);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'h0);

        // Random traffic with occasional redirects and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset(1'b0);
            end else begin
                applyStimulus($urandom_range(0, 99) < 70,
                              $urandom_range(0, 99) < 8,
                              16'($urandom));
            end
        end

`ifdef FETCH_LOADER_EN
        // Boot loader: write 0xA, 0xB, finishing alongside the second word.
        doReset(1'b1);
        load_valid = 1'b1;
        load_data  = 32'hA;
        #1;
        checkOutput("load_we0", 32'(we_o), 32'd1);
        checkOutput("load_addr0", 32'(addr_o), 32'(RST_PC));
        checkOutput("load_re0", 32'(re_o), 32'd0);
        checkOutput("load_bus0", bus, 32'hA);
        @(negedge clk);
        load_data = 32'hB;
        load_done = 1'b1;
        #1;
        checkOutput("load_we1", 32'(we_o), 32'd1);
        checkOutput("load_addr1", 32'(addr_o), 32'(RST_PC + 16'd4));
        @(posedge clk);
        modelLoading = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        load_done  = 1'b0;
        checkOutput("mem_word0", mem[RST_PC[15:2]], 32'hA);
        checkOutput("mem_word1", mem[RST_PC[15:2] + 14'd1], 32'hB);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
